// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave pipelined Wishbone arbiter.
// The winner is registered; once a master owns the bus, the slave-side
// signals are combinational muxes of that owner. The owner keeps the bus
// until it drops cyc, and it cannot be preempted. The arbiter counts strobes
// that the slave has accepted but not yet acked. Once that count reaches
// MAX_OUT, it holds off further strobes. Selection is round-robin from a
// rotating pointer or fixed priority, where the lowest index wins.
module wb_arbiter_rr #(
    parameter int NPORTS    = 4,
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_OUT   = 4,
    localparam int SWIDTH   = DWIDTH / 8,
    localparam int CWIDTH   = $clog2(MAX_OUT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NPORTS*AWIDTH-1:0] m_adr_i,
    input  logic [NPORTS-1:0]        m_cyc_i,
    input  logic [NPORTS-1:0]        m_stb_i,
    input  logic [NPORTS-1:0]        m_we_i,
    input  logic [NPORTS*SWIDTH-1:0] m_sel_i,
    input  logic [NPORTS*DWIDTH-1:0] m_dat_i,
    output logic [NPORTS-1:0]        m_ack_o,
    output logic [NPORTS-1:0]        m_stall_o,
    output logic [DWIDTH-1:0]        m_dat_o,
    output logic [AWIDTH-1:0]        s_adr_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [SWIDTH-1:0]        s_sel_o,
    output logic [DWIDTH-1:0]        s_dat_o,
    input  logic                     s_ack_i,
    input  logic                     s_stall_i,
    input  logic [DWIDTH-1:0]        s_dat_i,
    output logic [NPORTS-1:0]        grant_o,
    output logic [CWIDTH-1:0]        outstanding_o
);

    localparam int PWIDTH = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CWIDTH-1:0] CNT_MAX   = CWIDTH'(MAX_OUT);
    localparam logic [PWIDTH-1:0] LAST_PORT = PWIDTH'(NPORTS - 1);

    // Scans the requests starting at 'start' and wraps at NPORTS-1 -> 0.
    // It returns {found, index} of the first requester it meets. The loop
    // runs from the far end backwards, so the nearest requester is the last
    // write and wins.
    function automatic logic [PWIDTH:0] arb_pick(input logic [NPORTS-1:0] req,
                                                 input logic [PWIDTH-1:0] start);
        logic [PWIDTH:0]   res;
        logic [PWIDTH-1:0] idx;
        int                k;
        res = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= NPORTS) begin
                k = k - NPORTS;
            end else begin
                k = k;
            end
            idx = PWIDTH'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [0:0]        state_q, state_d;
    logic [PWIDTH-1:0] owner_q, owner_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [CWIDTH-1:0] cnt_q,   cnt_d;
    logic [PWIDTH-1:0] ptr_q,   ptr_d;

    logic              busy_s;
    logic              own_cyc_s;
    logic              own_stb_s;
    logic              full_s;
    logic              accept_s;
    logic              ack_cnt_s;
    logic [PWIDTH-1:0] start_s;
    logic [PWIDTH:0]   pick_s;
    logic              win_found_s;
    logic [PWIDTH-1:0] win_idx_s;

    assign busy_s      = (state_q == ST_BUSY);
    assign full_s      = (cnt_q == CNT_MAX);
    assign start_s     = (PRIO_MODE != 0) ? '0 : ptr_q;
    assign pick_s      = arb_pick(m_cyc_i, start_s);
    assign win_found_s = pick_s[PWIDTH];
    assign win_idx_s   = pick_s[PWIDTH-1:0];

    // Route the owner's request signals to the slave through an AND-OR mux.
    always_comb begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_sel_o   = '0;
        s_dat_o   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            own_cyc_s = own_cyc_s | (m_cyc_i[k] & (owner_q == PWIDTH'(k)));
            own_stb_s = own_stb_s | (m_stb_i[k] & (owner_q == PWIDTH'(k)));
            s_we_o    = s_we_o    | (m_we_i[k]  & (owner_q == PWIDTH'(k)));
            s_adr_o   = s_adr_o | (m_adr_i[k*AWIDTH +: AWIDTH] & {AWIDTH{owner_q == PWIDTH'(k)}});
            s_sel_o   = s_sel_o | (m_sel_i[k*SWIDTH +: SWIDTH] & {SWIDTH{owner_q == PWIDTH'(k)}});
            s_dat_o   = s_dat_o | (m_dat_i[k*DWIDTH +: DWIDTH] & {DWIDTH{owner_q == PWIDTH'(k)}});
        end
    end

    // The slave cycle and strobe follow the owner. The strobe is held off
    // once the outstanding window is full.
    assign s_cyc_o = busy_s & own_cyc_s;
    assign s_stb_o = busy_s & own_stb_s & ~full_s;

    // Acks and stalls reach the owner only. grant_q is zero while idle, so
    // every master then sees stall=1 and ack=0.
    assign m_ack_o   = grant_q & {NPORTS{s_ack_i}};
    assign m_stall_o = ~grant_q | {NPORTS{s_stall_i | full_s}};
    assign m_dat_o   = s_dat_i;

    assign grant_o       = grant_q;
    assign outstanding_o = cnt_q;

    // An ack only decrements a non-zero count. Extra acks still reach the owner.
    assign accept_s  = s_stb_o & ~s_stall_i;
    assign ack_cnt_s = busy_s & s_ack_i & (cnt_q != '0);

    // Ownership FSM: grant, hold, release (with direct hand-over) and counting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (win_found_s) begin
                    state_d = ST_BUSY;
                    owner_d = win_idx_s;
                    grant_d = {{(NPORTS-1){1'b0}}, 1'b1} << win_idx_s;
                    if (PRIO_MODE == 0) begin
                        ptr_d = (win_idx_s == LAST_PORT) ? '0 : win_idx_s + PWIDTH'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!own_cyc_s) begin
                    // The owner has released the bus. Unacked transfers are
                    // abandoned, and any acks that arrive later are dropped.
                    cnt_d = '0;
                    if (win_found_s) begin
                        state_d = ST_BUSY;
                        owner_d = win_idx_s;
                        grant_d = {{(NPORTS-1){1'b0}}, 1'b1} << win_idx_s;
                        if (PRIO_MODE == 0) begin
                            ptr_d = (win_idx_s == LAST_PORT) ? '0 : win_idx_s + PWIDTH'(1);
                        end else begin
                            ptr_d = ptr_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                        grant_d = '0;
                    end
                end else begin
                    if (accept_s && !ack_cnt_s) begin
                        cnt_d = cnt_q + CWIDTH'(1);
                    end else if (!accept_s && ack_cnt_s) begin
                        cnt_d = cnt_q - CWIDTH'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr. Two instances share one stimulus: a round-robin
// instance with MAX_OUT=2 and a fixed-priority instance with MAX_OUT=4.
// Each instance is compared every cycle against an integer-level model of
// the ownership rules.
module tb_wb_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*AW-1:0]   m_adr;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*SW-1:0]   m_sel;
    logic [N*DW-1:0]   m_dat;
    logic              s_ack, s_stall;
    logic [DW-1:0]     s_dat;

    logic [N-1:0]  ra_ack, ra_stall, ra_grant, fa_ack, fa_stall, fa_grant;
    logic [DW-1:0] ra_mdat, ra_sdat, fa_mdat, fa_sdat;
    logic [AW-1:0] ra_adr, fa_adr;
    logic          ra_cyc, ra_stb, ra_we, fa_cyc, fa_stb, fa_we;
    logic [SW-1:0] ra_sel, fa_sel;
    logic [1:0]    ra_out;
    logic [2:0]    fa_out;

    wb_arbiter_rr #(.NPORTS(N), .AWIDTH(AW), .DWIDTH(DW), .PRIO_MODE(0), .MAX_OUT(2)) u_rr (
        .clk_i(clk), .rst_i(rst), .m_adr_i(m_adr), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_we_i(m_we), .m_sel_i(m_sel), .m_dat_i(m_dat), .m_ack_o(ra_ack),
        .m_stall_o(ra_stall), .m_dat_o(ra_mdat), .s_adr_o(ra_adr), .s_cyc_o(ra_cyc),
        .s_stb_o(ra_stb), .s_we_o(ra_we), .s_sel_o(ra_sel), .s_dat_o(ra_sdat),
        .s_ack_i(s_ack), .s_stall_i(s_stall), .s_dat_i(s_dat), .grant_o(ra_grant),
        .outstanding_o(ra_out));

    wb_arbiter_rr #(.NPORTS(N), .AWIDTH(AW), .DWIDTH(DW), .PRIO_MODE(1), .MAX_OUT(4)) u_fp (
        .clk_i(clk), .rst_i(rst), .m_adr_i(m_adr), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_we_i(m_we), .m_sel_i(m_sel), .m_dat_i(m_dat), .m_ack_o(fa_ack),
        .m_stall_o(fa_stall), .m_dat_o(fa_mdat), .s_adr_o(fa_adr), .s_cyc_o(fa_cyc),
        .s_stb_o(fa_stb), .s_we_o(fa_we), .s_sel_o(fa_sel), .s_dat_o(fa_sdat),
        .s_ack_i(s_ack), .s_stall_i(s_stall), .s_dat_i(s_dat), .grant_o(fa_grant),
        .outstanding_o(fa_out));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model, index 0 = round-robin instance, 1 = fixed priority.
    int own  [2];   // owning master, -1 when idle
    int cnt  [2];
    int ptr  [2];
    int maxo [2] = '{2, 4};
    int mode [2] = '{0, 1};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input int inst);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (mode[inst] != 0) ? i : (ptr[inst] + i) % N;
            if (m_cyc[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_take(input int inst, input int w);
        own[inst] = w;
        if (mode[inst] == 0) ptr[inst] = (w + 1) % N;
    endtask

    task automatic model_step(input int inst);
        int w;
        if (rst) begin
            own[inst] = -1; cnt[inst] = 0; ptr[inst] = 0;
        end else if (own[inst] < 0) begin
            w = model_pick(inst);
            if (w >= 0) model_take(inst, w);
        end else if (!m_cyc[own[inst]]) begin
            cnt[inst] = 0;
            w = model_pick(inst);
            if (w >= 0) model_take(inst, w);
            else own[inst] = -1;
        end else begin
            int inc, dec;
            inc = (m_stb[own[inst]] && cnt[inst] < maxo[inst] && !s_stall) ? 1 : 0;
            dec = (s_ack && cnt[inst] > 0) ? 1 : 0;
            cnt[inst] = cnt[inst] + inc - dec;
        end
    endtask

    task automatic compare_inst(input int inst);
        logic [N-1:0]  g, ack, stall, e_g, e_ack, e_stall;
        logic          cyc, stb, we, e_cyc, e_stb;
        logic [AW-1:0] adr;
        logic [SW-1:0] sel;
        logic [DW-1:0] dat, mdat;
        int            outs, o;
        string         p;
        if (inst == 0) begin
            g = ra_grant; ack = ra_ack; stall = ra_stall; cyc = ra_cyc; stb = ra_stb;
            we = ra_we; adr = ra_adr; sel = ra_sel; dat = ra_sdat; mdat = ra_mdat;
            outs = int'(ra_out); p = "rr_";
        end else begin
            g = fa_grant; ack = fa_ack; stall = fa_stall; cyc = fa_cyc; stb = fa_stb;
            we = fa_we; adr = fa_adr; sel = fa_sel; dat = fa_sdat; mdat = fa_mdat;
            outs = int'(fa_out); p = "fp_";
        end
        o = own[inst];
        e_g = '0; e_ack = '0; e_stall = '1; e_cyc = 1'b0; e_stb = 1'b0;
        if (o >= 0) begin
            e_g[o]     = 1'b1;
            e_cyc      = m_cyc[o];
            e_stb      = m_stb[o] && (cnt[inst] < maxo[inst]);
            e_ack[o]   = s_ack;
            e_stall[o] = s_stall || (cnt[inst] == maxo[inst]);
        end
        check_eq({p, "grant"}, g, e_g);
        check_eq({p, "outstanding"}, outs, cnt[inst]);
        check_eq({p, "s_cyc"}, cyc, e_cyc);
        check_eq({p, "s_stb"}, stb, e_stb);
        check_eq({p, "m_ack"}, ack, e_ack);
        check_eq({p, "m_stall"}, stall, e_stall);
        check_eq({p, "m_dat"}, mdat, s_dat);
        if (e_cyc) begin
            check_eq({p, "s_adr"}, adr, m_adr[o*AW +: AW]);
            check_eq({p, "s_sel"}, sel, m_sel[o*SW +: SW]);
            check_eq({p, "s_dat"}, dat, m_dat[o*DW +: DW]);
            check_eq({p, "s_we"}, we, m_we[o]);
        end
    endtask

    task automatic payload();
        for (int k = 0; k < N; k++) begin
            m_adr[k*AW +: AW] = $urandom;
            m_dat[k*DW +: DW] = $urandom;
            m_sel[k*SW +: SW] = SW'($urandom);
            m_we[k]           = 1'($urandom_range(1));
        end
        s_dat = $urandom;
    endtask

    task automatic drive(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                         input logic ack, input logic stall);
        m_cyc = cyc; m_stb = stb; s_ack = ack; s_stall = stall;
        payload();
    endtask

    // Called just after a falling edge: let inputs settle, compare both instances.
    task automatic settle();
        #2;
        compare_inst(0);
        compare_inst(1);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        settle();
        advance();
        rst = 1'b0;
    endtask

    int           phase [N];
    logic [N-1:0] want, prev_g, prev_cyc;
    logic [N-1:0] exp_order [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    int           seen;
    int           waits [N];

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_dat = '0;
        s_ack = 1'b0; s_stall = 1'b0; s_dat = '0;
        for (int i = 0; i < 2; i++) begin own[i] = -1; cnt[i] = 0; ptr[i] = 0; end
        @(negedge clk);

        // Reset values.
        settle();
        check_eq("rst_grant", ra_grant, 4'b0000);
        check_eq("rst_out", ra_out, 2'd0);
        check_eq("rst_stall", ra_stall, 4'b1111);
        check_eq("rst_ack", ra_ack, 4'b0000);
        check_eq("rst_scyc", ra_cyc, 1'b0);
        advance();
        rst = 1'b0;

        // Master 2 alone: two pipelined reads, each acked 2 cycles after its strobe.
        drive(4'b0100, 4'b0100, 1'b0, 1'b0); settle();
        check_eq("t1_cyc_idle", ra_cyc, 1'b0); advance();
        drive(4'b0100, 4'b0100, 1'b0, 1'b0); settle();
        check_eq("t1_cyc_t1", ra_cyc, 1'b1); check_eq("t1_out0", ra_out, 2'd0); advance();
        drive(4'b0100, 4'b0100, 1'b0, 1'b0); settle();
        check_eq("t1_out1", ra_out, 2'd1); advance();
        drive(4'b0100, 4'b0000, 1'b1, 1'b0); settle();
        check_eq("t1_out2", ra_out, 2'd2); check_eq("t1_ack_a", ra_ack, 4'b0100); advance();
        drive(4'b0100, 4'b0000, 1'b1, 1'b0); settle();
        check_eq("t1_out3", ra_out, 2'd1); check_eq("t1_ack_b", ra_ack, 4'b0100); advance();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); settle();
        check_eq("t1_out4", ra_out, 2'd0); advance();

        // Round-robin among masters 0,1,3, each doing one-beat cycles.
        pulse_reset();
        for (int k = 0; k < N; k++) phase[k] = 0;
        want = 4'b1011; seen = 0; prev_g = '0;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            for (int k = 0; k < N; k++) begin
                m_cyc[k] = want[k] && (phase[k] != 2);
                m_stb[k] = want[k] && (phase[k] == 0);
            end
            s_ack = (ra_out != 2'd0); s_stall = 1'b0;
            payload();
            settle();
            if (ra_grant != '0 && ra_grant != prev_g) begin
                check_eq("rr_order", ra_grant, exp_order[seen]);
                seen++;
            end
            prev_g = ra_grant;
            for (int k = 0; k < N; k++) begin
                case (phase[k])
                    0: if (ra_grant[k] && m_stb[k] && !ra_stall[k]) phase[k] = 1;
                    1: if (ra_ack[k]) phase[k] = 2;
                    default: phase[k] = 0;
                endcase
            end
            advance();
        end
        check_eq("rr_order_count", seen, 6);

        // Fixed priority with masters 1 and 2 requesting continuously.
        pulse_reset();
        for (int c = 0; c < 12; c++) begin
            drive(4'b0110, 4'b0110, 1'($urandom_range(1)), 1'($urandom_range(1)));
            settle();
            if (c > 0) begin
                check_eq("fp_owner", fa_grant, 4'b0010);
                check_eq("fp_stall2", fa_stall[2], 1'b1);
            end
            advance();
        end

        // Outstanding window saturates at MAX_OUT=2 when the slave never acks.
        pulse_reset();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); settle(); advance();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); settle(); advance();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); settle(); advance();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); settle();
        check_eq("sat_out", ra_out, 2'd2);
        check_eq("sat_stb", ra_stb, 1'b0);
        check_eq("sat_stall", ra_stall[0], 1'b1);
        advance();

        // Abort with one outstanding, then a late ack.
        pulse_reset();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); settle(); advance();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); settle(); advance();
        drive(4'b0001, 4'b0000, 1'b0, 1'b0); settle();
        check_eq("abort_out1", ra_out, 2'd1); advance();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); settle(); advance();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0); settle();
        check_eq("late_out", ra_out, 2'd0);
        check_eq("late_ack", ra_ack, 4'b0000);
        advance();

        // Reset while busy with two outstanding.
        pulse_reset();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0); settle(); advance();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0); settle(); advance();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0); settle(); advance();
        rst = 1'b1;
        drive(4'b1000, 4'b1000, 1'b0, 1'b0); settle();
        check_eq("mrst_out_before", ra_out, 2'd2); advance();
        rst = 1'b0;
        drive(4'b1000, 4'b1000, 1'b0, 1'b0); settle();
        check_eq("mrst_grant", ra_grant, 4'b0000);
        check_eq("mrst_scyc", ra_cyc, 1'b0);
        check_eq("mrst_out", ra_out, 2'd0);
        check_eq("mrst_stall", ra_stall, 4'b1111);
        advance();

        // Randomized traffic, plus a round-robin fairness bound.
        pulse_reset();
        m_cyc = '0; prev_g = '0; prev_cyc = '0;
        for (int k = 0; k < N; k++) waits[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!m_cyc[k]) m_cyc[k] = ($urandom_range(3) == 0);
                else if ($urandom_range(5) == 0) m_cyc[k] = 1'b0;
                m_stb[k] = m_cyc[k] && ($urandom_range(1) == 1);
            end
            s_stall = ($urandom_range(3) == 0);
            s_ack   = ($urandom_range(9) < 3);
            payload();
            settle();
            if (ra_grant != '0 && ra_grant != prev_g) begin
                int worst;
                worst = 0;
                for (int k = 0; k < N; k++) begin
                    if (ra_grant[k]) waits[k] = 0;
                    else if (prev_cyc[k]) waits[k] = waits[k] + 1;
                    if (waits[k] > worst) worst = waits[k];
                end
                check_eq("rr_fair", (worst <= N - 1), 1'b1);
            end
            for (int k = 0; k < N; k++) if (!m_cyc[k]) waits[k] = 0;
            prev_g = ra_grant;
            prev_cyc = m_cyc;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
